// File: rtl/asrm_subword_access_if.sv
// asrm_subword_access_if
//   Request/response and RAM-side bundle of the ASRM sub-word access unit.
//   slave  : the access unit (accepts requests, masters the RAM)
//   master : the address stage plus RAM model that drive it
//   Signals: req_* (request handshake), resp_* (completion pulse),
//            pop_offset (byte width of the latched access),
//            ram_* (single-port synchronous RAM, read data one cycle after ram_en).
interface asrm_subword_access_if #(
  parameter int wordsize = 16,
  parameter int addrsize = 16
);
  localparam int LB = $clog2(wordsize / 8);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [1:0]               req_size;
  logic                     req_signed;
  logic [addrsize-1:0]      req_addr;
  logic [wordsize-1:0]      req_wdata;
  logic                     resp_valid;
  logic                     resp_error;
  logic [wordsize-1:0]      resp_rdata;
  logic [5:0]               pop_offset;
  logic                     ram_en;
  logic                     ram_we;
  logic [addrsize-LB-1:0]   ram_addr;
  logic [wordsize-1:0]      ram_wdata;
  logic [wordsize-1:0]      ram_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_error, resp_rdata, pop_offset,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_error, resp_rdata, pop_offset,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/asrm_subword_access.sv
// asrm_subword_access
//   Sequential sub-word load/store unit in front of a single-port synchronous RAM.
//   Full-word, 32-, 16- and 8-bit accesses at any naturally aligned byte lane;
//   sub-word stores are merged by read-modify-write. Misaligned requests complete
//   with resp_error and touch no RAM.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high; aborts any access in flight
//     bus   - asrm_subword_access_if.slave (request, response, RAM side)
//   Optional feature macro: REDUCED_SIGN_EXTEND_EN (sign-extend narrow loads
//   when req_signed is set; zero extension otherwise).
//   addrsize is assumed to be at least 6 bits.
module asrm_subword_access #(
  parameter int wordsize = 16,
  parameter int addrsize = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  asrm_subword_access_if.slave      bus
);
  localparam int WB = wordsize / 8;
  localparam int LB = $clog2(WB);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t                r_state;
  logic                  r_write;
  logic [5:0]            r_bytes;
  logic [addrsize-1:0]   r_addr;
  logic [wordsize-1:0]   r_wdata;   // store data, replaced by the merged word in CAP
  logic [wordsize-1:0]   r_rdata;
  logic                  r_err;

  // Request decode: access bytes, clamped to the word so oversize requests act as full word
  logic [5:0]            w_req_bytes;
  logic [5:0]            w_bytes;
  logic [5:0]            w_off;
  logic                  w_misal;

  always_comb begin
    case (bus.req_size)
      2'b01:   w_req_bytes = 6'd4;
      2'b10:   w_req_bytes = 6'd2;
      2'b11:   w_req_bytes = 6'd1;
      default: w_req_bytes = 6'(WB);
    endcase
    w_bytes = (w_req_bytes >= 6'(WB)) ? 6'(WB) : w_req_bytes;
  end

  assign w_off   = 6'(bus.req_addr & addrsize'(WB - 1));
  assign w_misal = (w_off & (w_bytes - 6'd1)) != 6'd0;

  // Lane datapath on the latched request
  logic [5:0]            w_roff;
  logic [8:0]            w_sh;
  logic [wordsize-1:0]   w_lmask;
  logic [wordsize-1:0]   w_lane;
  logic [wordsize-1:0]   w_ext;
  logic [wordsize-1:0]   w_merge;

  assign w_roff  = 6'(r_addr & addrsize'(WB - 1));
  assign w_sh    = {w_roff, 3'b000};
  // Shifting by the full word width yields 0, so a full-word access gets an all-ones mask
  assign w_lmask = ~({wordsize{1'b1}} << {r_bytes, 3'b000});
  assign w_lane  = (bus.ram_rdata >> w_sh) & w_lmask;
  assign w_merge = (bus.ram_rdata & ~(w_lmask << w_sh)) | ((r_wdata & w_lmask) << w_sh);

`ifdef REDUCED_SIGN_EXTEND_EN
  logic                  r_signed;
  logic                  w_msb;
  // Top bit of the lane is the one mask bit whose upper neighbour is clear
  assign w_msb = |(w_lane & w_lmask & ~(w_lmask >> 1));
  assign w_ext = (r_signed && w_msb) ? (w_lane | ~w_lmask) : w_lane;
`else
  logic                  w_unused_signed;
  assign w_unused_signed = bus.req_signed;
  assign w_ext = w_lane;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_bytes <= 6'(WB);
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef REDUCED_SIGN_EXTEND_EN
      r_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_write <= bus.req_write;
          r_bytes <= w_bytes;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_rdata <= '0;
          r_err   <= w_misal;
`ifdef REDUCED_SIGN_EXTEND_EN
          r_signed <= bus.req_signed;
`endif
          if (w_misal)                                    r_state <= RESP;
          else if (bus.req_write && w_bytes == 6'(WB))    r_state <= WR;
          else                                            r_state <= RD;
        end
        RD:   r_state <= CAP;
        CAP: begin
          if (r_write) begin
            r_wdata <= w_merge;
            r_state <= WR;
          end else begin
            r_rdata <= w_ext;
            r_state <= RESP;
          end
        end
        WR:      r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // All outputs decode from registers only; reset drops ram_en/ram_we immediately
  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_error = r_err;
  assign bus.resp_rdata = r_rdata;
  assign bus.pop_offset = r_bytes;
  assign bus.ram_en     = (r_state == RD) || (r_state == WR);
  assign bus.ram_we     = (r_state == WR);
  assign bus.ram_addr   = r_addr[addrsize-1:LB];
  assign bus.ram_wdata  = r_wdata;
endmodule

// File: tb/tb_asrm_subword_access.sv
// tb_asrm_subword_access
//   Directed, table-driven bench for asrm_subword_access at wordsize=32, addrsize=16,
//   with a behavioural synchronous RAM and a hand-written reset-during-RMW sequence.
module tb_asrm_subword_access;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  asrm_subword_access_if #(.wordsize(32), .addrsize(16)) bus ();

  asrm_subword_access #(.wordsize(32), .addrsize(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr[5:0]] <= bus.ram_wdata;
      else            bus.ram_rdata <= mem[bus.ram_addr[5:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [15:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic [31:0] pop;
    logic [31:0] memw;
  } vec_t;

  // Issue one request and observe until resp_valid or the cycle budget runs out
  task automatic run(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [15:0] addr, input logic [31:0] wd,
                     output int lat, output logic err, output logic [31:0] rd,
                     output int we_cyc, output logic [31:0] we_dat, output logic [31:0] we_adr,
                     output logic any_ram, output logic rdy1);
    lat = 0; err = 1'bx; rd = 'x; we_cyc = 0; we_dat = 'x; we_adr = 'x; any_ram = 1'b0; rdy1 = 1'bx;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) rdy1 = bus.req_ready;
      if (bus.ram_en || bus.ram_we) any_ram = 1'b1;
      if (bus.ram_we && we_cyc == 0) begin
        we_cyc = k; we_dat = bus.ram_wdata; we_adr = 32'(bus.ram_addr);
      end
      if (bus.resp_valid) begin
        lat = k; err = bus.resp_error; rd = bus.resp_rdata;
        break;
      end
    end
  endtask

  vec_t        v [12];
  int          lat, we_cyc;
  logic        err, any_ram, rdy1, bad;
  logic [31:0] rd, we_dat, we_adr;
  logic [31:0] sx_ab, sx_beef;

  initial begin
`ifdef REDUCED_SIGN_EXTEND_EN
    sx_ab = 32'hFFFF_FFAB; sx_beef = 32'hFFFF_BEEF;
`else
    sx_ab = 32'h0000_00AB; sx_beef = 32'h0000_BEEF;
`endif
    //        wr    sz     sg    addr      wdata          lat err  rdata          pop  mem word
    v[0]  = '{1'b1, 2'b00, 1'b0, 16'h0010, 32'h11223344, 2, 1'b0, 32'h0,        4, 32'h11223344};
    v[1]  = '{1'b1, 2'b11, 1'b0, 16'h0011, 32'h000000AB, 4, 1'b0, 32'h0,        1, 32'h1122AB44};
    v[2]  = '{1'b0, 2'b10, 1'b0, 16'h0012, 32'h0,        3, 1'b0, 32'h00001122, 2, 32'h0};
    v[3]  = '{1'b0, 2'b11, 1'b1, 16'h0011, 32'h0,        3, 1'b0, sx_ab,        1, 32'h0};
    v[4]  = '{1'b0, 2'b10, 1'b0, 16'h0013, 32'h0,        1, 1'b1, 32'h0,        2, 32'h0};
    v[5]  = '{1'b1, 2'b01, 1'b0, 16'h0020, 32'hDEADBEEF, 2, 1'b0, 32'h0,        4, 32'hDEADBEEF};
    v[6]  = '{1'b1, 2'b10, 1'b0, 16'h0022, 32'h1234CAFE, 4, 1'b0, 32'h0,        2, 32'hCAFEBEEF};
    v[7]  = '{1'b0, 2'b11, 1'b0, 16'h0023, 32'h0,        3, 1'b0, 32'h000000CA, 1, 32'h0};
    v[8]  = '{1'b0, 2'b10, 1'b1, 16'h0020, 32'h0,        3, 1'b0, sx_beef,      2, 32'h0};
    v[9]  = '{1'b1, 2'b00, 1'b0, 16'h0022, 32'h99999999, 1, 1'b1, 32'h0,        4, 32'hCAFEBEEF};
    v[10] = '{1'b1, 2'b10, 1'b0, 16'h0021, 32'h77777777, 1, 1'b1, 32'h0,        2, 32'hCAFEBEEF};
    v[11] = '{1'b0, 2'b00, 1'b1, 16'h0010, 32'h0,        3, 1'b0, 32'h1122AB44, 4, 32'h0};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",     32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid",32'(bus.resp_valid), 32'd0);
    chk("rst_resp_error",32'(bus.resp_error), 32'd0);
    chk("rst_resp_rdata",bus.resp_rdata,      32'd0);
    chk("rst_ram_en",    32'(bus.ram_en),     32'd0);
    chk("rst_ram_we",    32'(bus.ram_we),     32'd0);
    chk("rst_ram_addr",  32'(bus.ram_addr),   32'd0);
    chk("rst_ram_wdata", bus.ram_wdata,       32'd0);
    chk("rst_pop",       32'(bus.pop_offset), 32'd4);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run(v[i].wr, v[i].sz, v[i].sg, v[i].addr, v[i].wd, lat, err, rd, we_cyc, we_dat, we_adr, any_ram, rdy1);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_error", i),   32'(err), 32'(v[i].err));
      chk($sformatf("v%0d_rdata", i),   rd,       v[i].rd);
      chk($sformatf("v%0d_pop", i),     32'(bus.pop_offset), v[i].pop);
      chk($sformatf("v%0d_ready_low", i), 32'(rdy1), 32'd0);
      if (v[i].err) begin
        chk($sformatf("v%0d_no_ram", i), 32'(any_ram), 32'd0);
      end
      if (v[i].wr) begin
        chk($sformatf("v%0d_mem", i), mem[v[i].addr[7:2]], v[i].memw);
      end
      if (v[i].wr && !v[i].err) begin
        chk($sformatf("v%0d_we_cycle", i), 32'(we_cyc), 32'(v[i].lat - 1));
        chk($sformatf("v%0d_we_data", i),  we_dat, v[i].memw);
        chk($sformatf("v%0d_we_addr", i),  we_adr, 32'(v[i].addr >> 2));
      end
    end

    // Reset during CAP of a byte store: no write, no response, RAM untouched
    run(1'b1, 2'b00, 1'b0, 16'h0030, 32'h55667788, lat, err, rd, we_cyc, we_dat, we_adr, any_ram, rdy1);
    chk("pre_store_latency", 32'(lat), 32'd2);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b11;
    bus.req_signed = 1'b0; bus.req_addr = 16'h0031; bus.req_wdata = 32'h00000099;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_en", 32'(bus.ram_en), 32'd1);
    @(negedge clk);                     // CAP
    reset = 1'b1;
    #1;
    chk("rst_abort_en", 32'(bus.ram_en), 32'd0);
    chk("rst_abort_we", 32'(bus.ram_we), 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (bus.ram_we || bus.resp_valid) bad = 1'b1;
    end
    chk("rst_abort_quiet", 32'(bad), 32'd0);
    chk("rst_abort_mem", mem[12], 32'h55667788);
    run(1'b0, 2'b11, 1'b0, 16'h0031, 32'h0, lat, err, rd, we_cyc, we_dat, we_adr, any_ram, rdy1);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", rd, 32'h00000077);
    chk("post_rst_pop", 32'(bus.pop_offset), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/asrm_subword_access.md
# asrm_subword_access

Sequential sub-word memory access unit between the ASRM address stage and a single-port synchronous RAM. Performs full-word, 32-, 16- and 8-bit loads and stores at any naturally aligned byte lane, merging sub-word stores by read-modify-write. Generalises reduced-behaviour handling to arbitrary lanes, adds a request/response handshake and misalignment detection, and reports the stack pop offset of each access.

## Interface
- wordsize, 16, data word width in bits; legal values are 8, 16, 32, 64, 128
- addrsize, 16, byte address width
- LB, derived, log2(wordsize/8); not user-settable
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 full word, 01 32-bit, 10 16-bit, 11 8-bit
- req_signed  in  1  sign-extend loads; used only when REDUCED_SIGN_EXTEND_EN is defined
- req_addr  in  addrsize  byte address
- req_wdata  in  wordsize  store data; the low access-width bits are used
- resp_valid  out  1  one-cycle completion pulse
- resp_error  out  1  misaligned; valid with resp_valid
- resp_rdata  out  wordsize  load data, right-aligned and extended; 0 for stores and errors
- pop_offset  out  6  byte width of the latched access
- ram_en  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- ram_addr  out  addrsize-LB  word address = req_addr >> LB
- ram_wdata  out  wordsize  full word written
- ram_rdata  in  wordsize  read data, valid the cycle after ram_en

## Operation
- Effective width: `req_size` gives the access width. If that width is not smaller than `wordsize`, the access is treated as a full word (size 00).
- Lane: byte offset = `req_addr[LB-1:0]`. Little-endian: lane k occupies bits [8k+7:8k].
- Misaligned: the byte offset is not a multiple of the access bytes. The request completes with `resp_error=1` and no RAM activity.
- Request latching: on `req_valid && req_ready`, the unit latches `req_write`, effective size, `req_signed`, address and write data.
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE → RESP if misaligned.
  - IDLE → WR for a full-word store.
  - IDLE → RD otherwise.
  - RD drives `ram_en=1` → CAP.
  - CAP registers `ram_rdata`.
    - Load: extract the lane into `resp_rdata` → RESP.
    - Sub-word store: merge the write data into that lane only → WR.
  - WR drives `ram_we=1`, `ram_en=1` and `ram_wdata` for exactly one cycle → RESP.
  - RESP asserts `resp_valid` for one cycle → IDLE.
- Load extension: zero-extended, unless sign extension is enabled (see Configuration).
- pop_offset: effective access bytes, i.e. 4, 2, 1, or wordsize/8 for full-word accesses. Updated on request acceptance and held until the next acceptance.
- Ignored requests: `req_valid` while not in IDLE is ignored, with no queuing. `resp_valid` has no backpressure.

## Timing
- Cycle T is the accept edge. Completion cycle (`resp_valid`):
  - misaligned: T+1
  - full-word store: T+2
  - load: T+3
  - sub-word store: T+4
- `ram_en`, `ram_we`, `ram_addr` and `ram_wdata` are decoded from registered state only. There is no combinational path from `req_*` to `ram_*`.
- `req_ready` is combinational on state, so it is low the cycle after acceptance.
- Reset values:
  - state IDLE
  - `req_ready=1`
  - `resp_valid=0`, `resp_error=0`, `resp_rdata=0`
  - `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`
  - `pop_offset=wordsize/8`
- Reset mid-operation aborts immediately: `ram_we` and `ram_en` drop asynchronously, no response is issued, and the partial RMW is discarded.
- wordsize=8: every size degrades to full word; no RMW occurs; `pop_offset=1`.

## Configuration
- REDUCED_SIGN_EXTEND_EN
  - Defined: loads narrower than `wordsize` with `req_signed=1` replicate the lane's MSB into the upper bits of `resp_rdata`.
  - Undefined: `req_signed` is ignored and all loads are zero-extended.
  - The port exists in both builds.

## Test plan
All scenarios use wordsize=32, addrsize=16.
- Full-word store: 0x11223344 to addr 0x0010 → `ram_we` at T+1 with `ram_addr=0x004` and `ram_wdata=0x11223344`; `resp_valid` at T+2; `pop_offset=4`.
- Byte store: 0xAB to 0x0011 on that word → RD at T+1, WR at T+3 with `ram_wdata=0x1122AB44`; `resp_valid` at T+4; `pop_offset=1`.
- Half load: from 0x0012 → `resp_rdata=0x00001122` at T+3; `pop_offset=2`.
- Byte load with `req_signed=1`: from 0x0011 → `resp_rdata=0xFFFFFFAB` with the macro, 0x000000AB without.
- Misaligned half load: at 0x0013 → `resp_valid` and `resp_error` at T+1; `ram_en` and `ram_we` never high.
- Reset mid-RMW: assert reset during CAP of a byte store → `ram_we` never asserts and RAM is unchanged. The next request after reset completes normally.
